// File: rtl/jtsdram_bank_check.sv
// Per-bank SDRAM pattern tester: writes an LFSR pattern over the bank, reads it back and
// latches a sticky bad flag on data mismatch or controller timeout.
module jtsdram_bank_check #(
    parameter int unsigned AW   = 22,
    parameter logic [15:0] SEED = 16'haaaa,
    parameter int unsigned TOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          dwnld_busy,
    input  logic          clr,
    output logic          ba_rd,
    output logic          ba_wr,
    output logic [AW-1:0] ba_addr,
    output logic [15:0]   ba_din,
    input  logic          ba_ack,
    input  logic          ba_rdy,
    input  logic [15:0]   ba_dout,
    output logic          bad,
    output logic [7:0]    err_cnt,
    output logic [7:0]    pass_cnt
);

    localparam logic [7:0] TOUT8 = 8'(TOUT);

    typedef enum logic [2:0] {StIdle, StWreq, StWwait, StRreq, StRwait} state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [15:0] pattern;
    logic [7:0]  timer;
    logic [7:0]  err_base;
    logic [7:0]  pass_base;
    logic        in_wait;
    logic        timeout;
    logic        done;
    logic        err;
    logic        last_addr;

    // Odd passes use inverted data so every cell sees both polarities
    assign pattern   = lfsr ^ {16{pass_cnt[0]}};
    assign ba_din    = ba_wr ? pattern : 16'h0000;
    assign lfsr_nxt  = {^{lfsr[15], lfsr[14], lfsr[12], lfsr[9], lfsr[7], lfsr[4], lfsr[2],
                          lfsr[0]}, lfsr[15:1]};
    assign in_wait   = (state == StWwait) || (state == StRwait);
    assign timeout   = in_wait && !ba_rdy && (timer == TOUT8);
    assign done      = in_wait && (ba_rdy || timeout);
    assign err       = timeout || ((state == StRwait) && ba_rdy && (ba_dout != pattern));
    assign last_addr = &ba_addr;
    // clr is applied first so an error on the same edge still counts
    assign err_base  = clr ? 8'd0 : err_cnt;
    assign pass_base = clr ? 8'd0 : pass_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            ba_rd    <= 1'b0;
            ba_wr    <= 1'b0;
            ba_addr  <= '0;
            lfsr     <= SEED;
            timer    <= 8'd0;
            bad      <= 1'b0;
            err_cnt  <= 8'd0;
            pass_cnt <= 8'd0;
        end else begin
            if (err) begin
                bad     <= 1'b1;
                err_cnt <= (err_base == 8'hff) ? err_base : err_base + 8'd1;
            end else begin
                if (clr) bad <= 1'b0;
                err_cnt <= err_base;
            end
            pass_cnt <= pass_base;

            case (state)
                StIdle: begin
                    if (enable && !dwnld_busy) begin
                        lfsr    <= SEED;
                        ba_addr <= '0;
                        state   <= StWreq;
                    end
                end
                StWreq, StRreq: begin
                    if (ba_wr || ba_rd) begin
                        if (ba_ack) begin
                            ba_wr <= 1'b0;
                            ba_rd <= 1'b0;
                            timer <= 8'd0;
                            state <= (state == StWreq) ? StWwait : StRwait;
                        end
                    end else if (!enable) begin
                        ba_addr <= '0;
                        state   <= StIdle;
                    end else if (!dwnld_busy) begin
                        ba_wr <= (state == StWreq);
                        ba_rd <= (state == StRreq);
                    end
                end
                StWwait, StRwait: begin
                    timer <= timer + 8'd1;
                    if (done) begin
                        lfsr <= last_addr ? SEED : lfsr_nxt;
                        if ((state == StRwait) && last_addr) pass_cnt <= pass_base + 8'd1;
                        if (!enable) begin
                            ba_addr <= '0;
                            state   <= StIdle;
                        end else begin
                            ba_addr <= ba_addr + 1'b1;
                            if (last_addr) state <= (state == StWwait) ? StRreq : StWreq;
                            else           state <= (state == StWwait) ? StWreq : StRreq;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_jtsdram_bank_check.sv
// Directed bench for jtsdram_bank_check: 16-word bank with a behavioural memory that can
// corrupt a read or withhold rdy, plus busy / enable / clr / reset corner sequences.
module tb_jtsdram_bank_check;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        dwnld_busy;
    logic        clr;
    logic        ba_rd;
    logic        ba_wr;
    logic [3:0]  ba_addr;
    logic [15:0] ba_din;
    logic        ba_ack;
    logic        ba_rdy;
    logic [15:0] ba_dout;
    logic        bad;
    logic [7:0]  err_cnt;
    logic [7:0]  pass_cnt;

    jtsdram_bank_check #(.AW(4), .SEED(16'haaaa), .TOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .dwnld_busy (dwnld_busy),
        .clr        (clr),
        .ba_rd      (ba_rd),
        .ba_wr      (ba_wr),
        .ba_addr    (ba_addr),
        .ba_din     (ba_din),
        .ba_ack     (ba_ack),
        .ba_rdy     (ba_rdy),
        .ba_dout    (ba_dout),
        .bad        (bad),
        .err_cnt    (err_cnt),
        .pass_cnt   (pass_cnt)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] mem [16];
    logic [15:0] exp_lfsr [16];
    logic        exp_inv = 1'b0;
    int          flip_addr = -1;
    int          nordy_addr = -1;
    bit          flip_hit = 1'b0;

    typedef struct {
        bit          flip;
        bit          busy;
        logic [15:0] din0;
        logic [15:0] din1;
        logic [7:0]  pass;
        logic        bad;
        logic [7:0]  err;
    } vec_t;
    vec_t tbl [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired, got no event expected event", name);
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // Returns in the cycle the model acks a request of the given kind and address
    task automatic wait_ack(input bit wr, input int a);
        for (int i = 0; i < 600; i++) begin
            if (ba_ack && (wr ? ba_wr : ba_rd) && int'(ba_addr) == a) return;
            step();
        end
        fail_timeout($sformatf("ack_%s_%0d", wr ? "wr" : "rd", a));
    endtask

    task automatic wait_pass(input logic [7:0] target);
        for (int i = 0; i < 1000; i++) begin
            if (pass_cnt == target) return;
            step();
        end
        fail_timeout($sformatf("pass_%0d", target));
    endtask

    // Memory model: ack the cycle a request is seen, rdy two cycles later
    initial begin
        logic [3:0] p_addr;
        bit         p_wr;
        int         pend;
        ba_ack  = 1'b0;
        ba_rdy  = 1'b0;
        ba_dout = 16'h0;
        pend    = 0;
        p_addr  = '0;
        p_wr    = 1'b0;
        forever begin
            @(negedge clk);
            ba_ack = 1'b0;
            ba_rdy = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ba_rdy = 1'b1;
                    if (!p_wr) begin
                        ba_dout = mem[p_addr];
                        if (int'(p_addr) == flip_addr) begin
                            ba_dout[3] = ~ba_dout[3];
                            flip_hit   = 1'b1;
                        end
                    end
                end
            end else if (ba_wr || ba_rd) begin
                ba_ack = 1'b1;
                p_wr   = ba_wr;
                p_addr = ba_addr;
                if (ba_wr) begin
                    mem[ba_addr] = ba_din;
                    check($sformatf("wr_din_%0d", ba_addr), ba_din,
                          exp_lfsr[ba_addr] ^ {16{exp_inv}});
                    if (int'(ba_addr) != nordy_addr) pend = 2;
                end else begin
                    pend = 2;
                end
            end
        end
    end

    initial begin
        logic [15:0] l;
        int          reqs;
        l = 16'haaaa;
        for (int i = 0; i < 16; i++) begin
            exp_lfsr[i] = l;
            l = {^{l[15], l[14], l[12], l[9], l[7], l[4], l[2], l[0]}, l[15:1]};
        end
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;

        tbl[0] = '{flip: 1'b0, busy: 1'b0, din0: 16'haaaa, din1: 16'hd555, pass: 8'd1,
                   bad: 1'b0, err: 8'd0};
        tbl[1] = '{flip: 1'b1, busy: 1'b0, din0: 16'h5555, din1: 16'h2aaa, pass: 8'd2,
                   bad: 1'b1, err: 8'd1};
        tbl[2] = '{flip: 1'b0, busy: 1'b1, din0: 16'haaaa, din1: 16'hd555, pass: 8'd3,
                   bad: 1'b1, err: 8'd1};

        rst_n      = 1'b0;
        enable     = 1'b0;
        dwnld_busy = 1'b0;
        clr        = 1'b0;
        repeat (3) step();
        check("rst_ba_rd", ba_rd, 1'b0);
        check("rst_ba_wr", ba_wr, 1'b0);
        check("rst_ba_addr", ba_addr, 4'h0);
        check("rst_ba_din", ba_din, 16'h0);
        check("rst_bad", bad, 1'b0);
        check("rst_err_cnt", err_cnt, 8'd0);
        check("rst_pass_cnt", pass_cnt, 8'd0);
        rst_n  = 1'b1;
        step();
        enable = 1'b1;

        for (int v = 0; v < 3; v++) begin
            if (tbl[v].flip) begin
                flip_hit  = 1'b0;
                flip_addr = 5;
            end
            wait_ack(1'b1, 0);
            check($sformatf("v%0d_din0", v), ba_din, tbl[v].din0);
            wait_ack(1'b1, 1);
            check($sformatf("v%0d_din1", v), ba_din, tbl[v].din1);
            if (tbl[v].flip) begin
                for (int i = 0; i < 600 && !flip_hit; i++) step();
                if (!flip_hit) fail_timeout("flip_rdy");
                check("flip_bad_before", bad, 1'b0);
                step();
                check("flip_bad_after", bad, 1'b1);
                check("flip_err_after", err_cnt, 8'd1);
                flip_addr = -1;
            end
            if (tbl[v].busy) begin
                wait_ack(1'b1, 7);
                dwnld_busy = 1'b1;
                reqs = 0;
                for (int i = 0; i < 40; i++) begin
                    step();
                    if (ba_wr || ba_rd) reqs++;
                end
                check("busy_no_req", reqs, 0);
                dwnld_busy = 1'b0;
                wait_ack(1'b1, 8);
                check("busy_resume_addr", ba_addr, 4'd8);
                check("busy_resume_din", ba_din, exp_lfsr[8]);
            end
            wait_pass(tbl[v].pass);
            check($sformatf("v%0d_pass", v), pass_cnt, tbl[v].pass);
            check($sformatf("v%0d_bad", v), bad, tbl[v].bad);
            check($sformatf("v%0d_err", v), err_cnt, tbl[v].err);
            exp_inv = ~exp_inv;
        end

        // enable dropped mid-read: finish read of addr 4, then park in IDLE at addr 0
        wait_ack(1'b0, 4);
        enable = 1'b0;
        repeat (8) step();
        check("idle_ba_rd", ba_rd, 1'b0);
        check("idle_ba_wr", ba_wr, 1'b0);
        check("idle_addr", ba_addr, 4'd0);
        check("idle_pass_kept", pass_cnt, 8'd3);
        check("idle_bad_kept", bad, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_bad", bad, 1'b0);
        check("clr_err", err_cnt, 8'd0);
        check("clr_pass", pass_cnt, 8'd0);
        exp_inv = 1'b0;

        // write to addr 2 never gets rdy: timeout after 16 cycles, then addr 3
        nordy_addr = 2;
        enable     = 1'b1;
        wait_ack(1'b1, 2);
        repeat (16) step();
        check("tout_bad_before", bad, 1'b0);
        step();
        check("tout_bad_after", bad, 1'b1);
        check("tout_err", err_cnt, 8'd1);
        wait_ack(1'b1, 3);
        check("tout_next_addr", ba_addr, 4'd3);
        nordy_addr = -1;
        wait_pass(8'd1);
        check("tout_pass", pass_cnt, 8'd1);
        check("tout_err_end", err_cnt, 8'd1);
        exp_inv = 1'b1;

        // asynchronous reset while a read request is up
        for (int i = 0; i < 600 && !ba_rd; i++) step();
        if (!ba_rd) fail_timeout("rd_req");
        rst_n = 1'b0;
        #1;
        check("arst_ba_rd", ba_rd, 1'b0);
        check("arst_addr", ba_addr, 4'd0);
        check("arst_bad", bad, 1'b0);
        check("arst_err", err_cnt, 8'd0);
        check("arst_pass", pass_cnt, 8'd0);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
